// File: rtl/alu_pkg.sv
// Shared encodings for the alu operand sequencer: FSM phases, alu op codes and modes.
package alu_pkg;

   typedef enum logic [2:0] {
      ST_LOAD_A  = 3'd0,
      ST_LOAD_B  = 3'd1,
      ST_LOAD_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SHOW    = 3'd4
   } seq_state_e;

   localparam logic MODE_LOGIC = 1'b0;
   localparam logic MODE_ARITH = 1'b1;

   // Logical-mode op codes
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NAND = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_NOTA = 3'b110;
   localparam logic [2:0] OP_NOTB = 3'b111;

   // Arithmetic-mode op codes
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;
   localparam logic [2:0] OP_RSUB = 3'b101;
   localparam logic [2:0] OP_INC  = 3'b110;
   localparam logic [2:0] OP_DEC  = 3'b111;

endpackage

// File: rtl/alu_op_sequencer_btn_edge.sv
// Rising-edge detector on a debounced button level. History resets high so a
// button held through reset release produces no event.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic evt_o
);

   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b1;
      else     prev_q <= btn_i;
   end

   assign evt_o = btn_i & ~prev_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Steps operands/op from the switches into the alu, waits SETTLE cycles, then
// captures the alu result for display; optionally chains the result into A.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw_data,
   input  logic       sw_cin,
   input  logic       sw_mode,
   input  logic       sw_chain,
   input  logic       btn_next,
   input  logic       btn_clr,
   input  logic [3:0] alu_out,
   input  logic       alu_c_out,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic       alu_c_in,
   output logic       alu_mode,
   output logic [2:0] alu_op,
   output logic [3:0] res,
   output logic       res_c,
   output logic       res_valid,
   output logic [2:0] phase
);

   localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

   seq_state_e state_q, state_d;
   logic [3:0] a_q, a_d, b_q, b_d, res_q, res_d, cnt_q, cnt_d;
   logic [2:0] op_q, op_d;
   logic       cin_q, cin_d, mode_q, mode_d, resc_q, resc_d, rv_q, rv_d;
   logic       next_evt, clr_evt;

   btn_edge u_next (.clk(clk), .rst(rst), .btn_i(btn_next), .evt_o(next_evt));
   btn_edge u_clr  (.clk(clk), .rst(rst), .btn_i(btn_clr),  .evt_o(clr_evt));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOAD_A;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         mode_q  <= 1'b0;
         op_q    <= '0;
         res_q   <= '0;
         resc_q  <= 1'b0;
         rv_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         mode_q  <= mode_d;
         op_q    <= op_d;
         res_q   <= res_d;
         resc_q  <= resc_d;
         rv_q    <= rv_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      mode_d  = mode_q;
      op_d    = op_q;
      res_d   = res_q;
      resc_d  = resc_q;
      rv_d    = rv_q;
      cnt_d   = cnt_q;

      if (clr_evt) begin
         // Clear beats a simultaneous next and aborts any pending capture.
         state_d = ST_LOAD_A;
         a_d     = '0;
         b_d     = '0;
         cin_d   = 1'b0;
         mode_d  = 1'b0;
         op_d    = '0;
         res_d   = '0;
         resc_d  = 1'b0;
         rv_d    = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_LOAD_A: if (next_evt) begin
               a_d     = sw_data;
               state_d = ST_LOAD_B;
            end
            ST_LOAD_B: if (next_evt) begin
               b_d     = sw_data;
               cin_d   = sw_cin;
               state_d = ST_LOAD_OP;
            end
            ST_LOAD_OP: if (next_evt) begin
               op_d    = sw_data[2:0];
               mode_d  = sw_mode;
               cnt_d   = '0;
               state_d = ST_EXEC;
            end
            ST_EXEC: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == CNT_LAST) begin
                  res_d   = alu_out;
                  resc_d  = alu_c_out;
                  rv_d    = 1'b1;
                  state_d = ST_SHOW;
               end
            end
            ST_SHOW: if (next_evt) begin
               rv_d = 1'b0;
               if (sw_chain) begin
                  a_d     = res_q;
                  state_d = ST_LOAD_B;
               end else begin
                  state_d = ST_LOAD_A;
               end
            end
            default: state_d = ST_LOAD_A;
         endcase
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_c_in  = cin_q;
   assign alu_mode  = mode_q;
   assign alu_op    = op_q;
   assign res       = res_q;
   assign res_c     = resc_q;
   assign res_valid = rv_q;
   assign phase     = state_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream controller for the 4-bit alu block. It collects operand A, operand B plus carry-in, and op plus mode from the board switches, one step per press of the "next" button. It drives these values onto the alu inputs, waits a fixed settle time, and registers the alu output and carry for the display path. It also supports chaining, where the registered result becomes the next operand A.

Parameters:
SETTLE, 2, cycles held in EXEC before the alu result is captured; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
sw_data  input  4  switch value used for A, B or op (op uses bits [2:0])
sw_cin  input  1  carry-in switch, sampled with B
sw_mode  input  1  mode switch (0 logical, 1 arithmetic), sampled with op
sw_chain  input  1  chain select, sampled on the press that leaves SHOW
btn_next  input  1  debounced level from the "next" button
btn_clr  input  1  debounced level from the "clear" button
alu_out  input  4  result from the alu
alu_c_out  input  1  carry from the alu
alu_a  output  4  operand A register to the alu
alu_b  output  4  operand B register to the alu
alu_c_in  output  1  carry-in register to the alu
alu_mode  output  1  mode register to the alu
alu_op  output  3  op register to the alu
res  output  4  captured result
res_c  output  1  captured carry
res_valid  output  1  high only while in SHOW
phase  output  3  current state encoding, for LEDs

Behaviour:
- Reset (asynchronous, active-high):
  - state LOAD_A.
  - alu_a, alu_b, alu_c_in, alu_mode, alu_op, res, res_c, res_valid and the settle counter all 0.
  - Both button-history flops reset to 1. A button held through reset release therefore gives no edge.
- Edge detect: next_evt = btn_next & ~prev_next, registered per clk; clr_evt formed the same way. Holding a button yields exactly one event.
- All alu_* outputs come straight from registers and are stable between loads.
- States and phase encodings: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4.
- LOAD_A, on next_evt: alu_a <= sw_data; go to LOAD_B.
- LOAD_B, on next_evt: alu_b <= sw_data and alu_c_in <= sw_cin; go to LOAD_OP.
- LOAD_OP, on next_evt: alu_op <= sw_data[2:0], alu_mode <= sw_mode, counter <= 0; go to EXEC.
- EXEC:
  - Counter increments every cycle; next_evt is ignored.
  - In the cycle where counter == SETTLE-1: res <= alu_out, res_c <= alu_c_out, res_valid <= 1; go to SHOW.
  - EXEC therefore lasts exactly SETTLE cycles. res is valid on the cycle SHOW is entered.
- SHOW, on next_evt:
  - res_valid <= 0 in all cases.
  - If sw_chain=1: alu_a <= res; go to LOAD_B. alu_b, alu_op and alu_mode are kept until reloaded.
  - Otherwise go to LOAD_A.
  - res and res_c hold their values until the next capture.
- clr_evt in any state:
  - Go to LOAD_A and clear every register to its reset value.
  - This includes mid-EXEC; no capture occurs.
  - clr_evt has priority over a simultaneous next_evt.
- No arithmetic is done here. Width mismatch: op takes sw_data[2:0], and sw_data[3] is ignored in LOAD_OP.
- Unreachable state encodings recover to LOAD_A on the next clk.

Decomposition:
- Shared package alu_pkg holds:
  - the state encodings (LOAD_A..SHOW);
  - the op code constants matching the alu (OP_AND=000 … OP_NOTB=111 in logical mode; OP_ADD=010, OP_SUB=011, OP_MUL=100, OP_RSUB=101, OP_INC=110, OP_DEC=111 in arithmetic mode);
  - MODE_LOGIC=0 and MODE_ARITH=1.
- One sub-module is natural: btn_edge, a registered rising-edge detector with reset value 1. It is instantiated twice, once for btn_next and once for btn_clr.

Test Plan:
- Bench setup: real alu instance, SETTLE=2. After each test, apply rst mid-operation and check that every output returns to 0 with phase=0.
- Add: sw_data=5, then 3 with cin=0, then op=010 with mode=1, three presses → phase 3 for 2 cycles, then res=8, res_c=0, res_valid=1, phase=4.
- Add overflow: A=F, B=1, op=010, mode=1 → res=0, res_c=1.
- Logical AND: A=C, B=A, op=000, mode=0 → res=8, res_c=0. Pulsing btn_next during EXEC leaves both capture timing and value unchanged.
- Chain: from res=8, set sw_chain=1 and press → alu_a=8, phase=1. Then B=2 and op=010 with mode=1 → res=A.
- Clear and held buttons:
  - btn_clr during EXEC (cycle 1) → phase=0 on the next cycle, res stays 0, res_valid=0.
  - btn_clr and btn_next asserted on the same cycle → clear wins.
  - btn_next held 10 cycles → exactly one state advance.
  - btn_next held high across rst release → no advance.
